l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- N-requester arbiter in front of the shared L2 port.
- Generalises the fixed two-port L1D/L1I grant logic and the flush sequencer to N_REQ L1 clients (L1D, L1I, page walker, prefetcher, ...).
- Keeps one L2 transaction outstanding at a time, chosen by rotating round-robin, and routes the response back to the granted client.
- Aggregates per-client flush completion into a single L2 flush; new: new grants are gated during the L2 flush, and protocol violations are flagged.

Parameters:
- N_REQ, 2, number of requesting clients (2..8).
- ADDR_W, 32, request address width.
- DATA_W, 128, cache-line store/load data width.
- OPC_W, 4, memory opcode width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  one-cycle request pulse per client.
- req_addr  in  N_REQ*ADDR_W  per-client address; client index i occupies [i*ADDR_W +: ADDR_W]; held stable until its rsp_valid.
- req_opcode  in  N_REQ*OPC_W  per-client opcode; held stable until its rsp_valid.
- req_store_data  in  N_REQ*DATA_W  per-client store data; held stable until its rsp_valid.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_load_data  out  DATA_W  L2 load data, broadcast to all clients.
- l2_req_valid  out  1  request to L2.
- l2_req_ack  in  1  L2 accepted the request.
- l2_req_addr  out  ADDR_W  address of the granted client.
- l2_req_opcode  out  OPC_W  opcode of the granted client.
- l2_req_store_data  out  DATA_W  store data of the granted client.
- l2_rsp_valid  in  1  L2 response.
- l2_rsp_load_data  in  DATA_W  L2 response data.
- flush_req  in  N_REQ  per-client flush-start pulse.
- flush_complete  in  N_REQ  per-client flush-done pulse.
- l2_flush_req  out  1  one-cycle L2 flush pulse.
- l2_flush_complete  in  1  L2 flush done.
- in_flush_mode  out  1  high from flush start until L2 flush done.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, reset_n=0) values:
  - Grant FSM = IDLE; pending = 0; last_gnt = N_REQ-1 (so client 0 wins first).
  - l2_req_valid = 0; rsp_valid = 0; proto_err = 0.
  - Flush FSM = F_IDLE; done_mask = 0; in_flush_mode = 0; l2_flush_req = 0.
  - Reset mid-transaction drops all state; L2 is reset alongside.
- Pending capture:
  - pending_next = pending | req_valid.
  - req_valid[i] while pending[i] or while i is granted: ignored, proto_err set.
- Grant FSM, IDLE:
  - Blocked while flush FSM is F_L2 or while l2_flush_req is asserted.
  - Otherwise, if pending_next != 0, pick the first set bit scanning (last_gnt+1) mod N_REQ upward with wrap.
  - Register gnt; clear pending[gnt]; last_gnt = gnt; l2_req_valid = 1 next cycle; go GNT.
  - Request-to-l2_req_valid latency: 1 cycle.
- Grant FSM, GNT:
  - l2_req_valid stays high until the cycle l2_req_ack=1; drops the next cycle.
  - l2_req_addr/opcode/store_data are combinational muxes of the gnt client's inputs.
  - On l2_rsp_valid: rsp_valid[gnt]=1 in the same cycle (combinational); rsp_load_data = l2_rsp_load_data; go IDLE.
  - Ack and rsp in the same cycle is legal.
  - Re-grant is possible in the next cycle (back-to-back).
- l2_rsp_valid in IDLE: ignored, proto_err set.
- Flush FSM, F_IDLE:
  - On any flush_req: done_mask = ~flush_req | flush_complete; in_flush_mode=1; go F_WAIT.
  - Non-requesting clients count as done.
- Flush FSM, F_WAIT:
  - done_mask |= flush_complete.
  - When done_mask (including the current-cycle flush_complete) is all ones: l2_flush_req=1 for exactly one cycle; go F_L2.
- Flush FSM, F_L2:
  - On l2_flush_complete: in_flush_mode=0; done_mask=0; go F_IDLE.
  - flush_req while not F_IDLE: ignored, proto_err set.
- An in-flight grant at flush entry completes normally.
- L1 writebacks during F_WAIT are arbitrated normally.

Decomposition:
- Shared package l2_arb_pkg:
  - grant_state_t {IDLE, GNT}.
  - flush_state_t {F_IDLE, F_WAIT, F_L2}.
  - Function rr_pick(pending, last) returning index and found bit.
- One sub-module, rr_priority_pick: parametrised N_REQ rotating priority encoder, purely combinational, also usable by the L2 MSHR.
- The rest is one module.

Test Plan:
- Single request: N_REQ=4, req_valid=4'b0100, addr 0x1000 → l2_req_valid next cycle with addr 0x1000; hold until ack; l2_rsp_valid with data 0xAA.. → rsp_valid=4'b0100 in the same cycle.
- Fairness: all four clients pulse together, L2 responds each after 3 cycles → grant order 0,1,2,3; a second burst gives 0,1,2,3 again; no client is served twice before all are served.
- Arrival during grant: client 2 granted, client 1 pulses mid-transaction → client 1 granted the cycle after client 2's rsp; same-cycle ack+rsp honoured.
- Flush subset: flush_req=4'b0011; complete[1] at t+5, complete[0] at t+9 → l2_flush_req pulses exactly once at t+9; in_flush_mode high t+1..until l2_flush_complete; a request pending during F_L2 is granted only after.
- Simultaneous flush edge: flush_req=4'b0001 with flush_complete=4'b0001 in the same cycle → l2_flush_req next cycle.
- Errors/reset: l2_rsp_valid in IDLE → proto_err=1, sticky; reset_n low mid-GNT → l2_req_valid, rsp_valid, in_flush_mode, proto_err all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and the rotating-priority search used by the L2 port arbiter and the L2 MSHR.
// The search is sized for up to MAX_REQ clients; callers zero-pad narrower request vectors.
package l2_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE,
        GNT
    } grant_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_L2
    } flush_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of pending, scanning from (last+1) mod n upward with wrap.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] pending,
                                         input logic [IDX_W-1:0]   last,
                                         input int unsigned        n);
        rr_pick_t    r;
        int unsigned c;
        r = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                c = (32'(last) + k) % n;
                if (!r.found && pending[c[IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = c[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: picks the first requester after 'last', wrapping at N_REQ.
// Purely combinational; no backpressure of its own.
module rr_priority_pick
    import l2_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int GW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    idx,
    output logic             found
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), IDX_W'(last), N_REQ);
        idx   = GW'(pick.idx);
        found = pick.found;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter for N_REQ L1 clients onto one L2 port, plus flush aggregation into one L2 flush.
// Latency: request pulse to l2_req_valid 1 cycle; response routed back combinationally.
// Backpressure: one L2 transaction outstanding; l2_req_valid holds until l2_req_ack; grants stall in the L2 flush.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int OPC_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*OPC_W-1:0]  req_opcode,
    input  logic [N_REQ*DATA_W-1:0] req_store_data,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_load_data,
    output logic                    l2_req_valid,
    input  logic                    l2_req_ack,
    output logic [ADDR_W-1:0]       l2_req_addr,
    output logic [OPC_W-1:0]        l2_req_opcode,
    output logic [DATA_W-1:0]       l2_req_store_data,
    input  logic                    l2_rsp_valid,
    input  logic [DATA_W-1:0]       l2_rsp_load_data,
    input  logic [N_REQ-1:0]        flush_req,
    input  logic [N_REQ-1:0]        flush_complete,
    output logic                    l2_flush_req,
    input  logic                    l2_flush_complete,
    output logic                    in_flush_mode,
    output logic                    proto_err
);

    localparam int GW = $clog2(N_REQ);
    localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);

    grant_state_t     gstate, gstate_nxt;
    flush_state_t     fstate, fstate_nxt;
    logic [N_REQ-1:0] pending, pending_nxt, pending_cap;
    logic [N_REQ-1:0] done_mask, done_mask_nxt;
    logic [N_REQ-1:0] gnt_mask, req_err_mask;
    logic [GW-1:0]    gnt, gnt_nxt, last_gnt, last_gnt_nxt, pick_idx;
    logic             pick_found, grant_blocked, l2_req_valid_nxt, proto_err_nxt;

    // A pulse from a client that is already queued or being served is dropped, not re-queued.
    assign gnt_mask     = (gstate == GNT) ? (N_REQ'(1) << gnt) : '0;
    assign req_err_mask = req_valid & (pending | gnt_mask);
    assign pending_cap  = pending | (req_valid & ~req_err_mask);

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (pending_cap),
        .last  (last_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign l2_req_addr       = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
    assign l2_req_opcode     = req_opcode[int'(gnt)*OPC_W +: OPC_W];
    assign l2_req_store_data = req_store_data[int'(gnt)*DATA_W +: DATA_W];
    assign rsp_load_data     = l2_rsp_load_data;
    assign rsp_valid         = l2_rsp_valid ? gnt_mask : '0;
    assign in_flush_mode     = (fstate != F_IDLE);
    assign grant_blocked     = (fstate == F_L2) || l2_flush_req;

    always_comb begin
        gstate_nxt       = gstate;
        pending_nxt      = pending_cap;
        gnt_nxt          = gnt;
        last_gnt_nxt     = last_gnt;
        l2_req_valid_nxt = l2_req_valid;
        case (gstate)
            IDLE: begin
                if (!grant_blocked && pick_found) begin
                    gnt_nxt          = pick_idx;
                    last_gnt_nxt     = pick_idx;
                    pending_nxt      = pending_cap & ~(N_REQ'(1) << pick_idx);
                    l2_req_valid_nxt = 1'b1;
                    gstate_nxt       = GNT;
                end
            end
            GNT: begin
                if (l2_req_ack) begin
                    l2_req_valid_nxt = 1'b0;
                end
                if (l2_rsp_valid) begin
                    l2_req_valid_nxt = 1'b0;
                    gstate_nxt       = IDLE;
                end
            end
            default: gstate_nxt = IDLE;
        endcase
    end

    // Clients not taking part in a flush count as already done.
    always_comb begin
        fstate_nxt    = fstate;
        done_mask_nxt = done_mask;
        l2_flush_req  = 1'b0;
        case (fstate)
            F_IDLE: begin
                if (|flush_req) begin
                    done_mask_nxt = ~flush_req | flush_complete;
                    fstate_nxt    = F_WAIT;
                end
            end
            F_WAIT: begin
                done_mask_nxt = done_mask | flush_complete;
                if (&done_mask_nxt) begin
                    l2_flush_req = 1'b1;
                    fstate_nxt   = F_L2;
                end
            end
            F_L2: begin
                if (l2_flush_complete) begin
                    done_mask_nxt = '0;
                    fstate_nxt    = F_IDLE;
                end
            end
            default: fstate_nxt = F_IDLE;
        endcase
    end

    assign proto_err_nxt = proto_err
                         | (|req_err_mask)
                         | (l2_rsp_valid && (gstate == IDLE))
                         | ((|flush_req) && (fstate != F_IDLE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gstate       <= IDLE;
            pending      <= '0;
            gnt          <= '0;
            last_gnt     <= LAST_RST;
            l2_req_valid <= 1'b0;
            proto_err    <= 1'b0;
            fstate       <= F_IDLE;
            done_mask    <= '0;
        end else begin
            gstate       <= gstate_nxt;
            pending      <= pending_nxt;
            gnt          <= gnt_nxt;
            last_gnt     <= last_gnt_nxt;
            l2_req_valid <= l2_req_valid_nxt;
            proto_err    <= proto_err_nxt;
            fstate       <= fstate_nxt;
            done_mask    <= done_mask_nxt;
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboarded bench for l2_port_arbiter with four clients and a small L2 responder model.
module tb_l2_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int OW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*OW-1:0] req_opcode;
    logic [N*DW-1:0] req_store_data;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_load_data;
    logic            l2_req_valid;
    logic            l2_req_ack;
    logic [AW-1:0]   l2_req_addr;
    logic [OW-1:0]   l2_req_opcode;
    logic [DW-1:0]   l2_req_store_data;
    logic            l2_rsp_valid;
    logic [DW-1:0]   l2_rsp_load_data;
    logic [N-1:0]    flush_req;
    logic [N-1:0]    flush_complete;
    logic            l2_flush_req;
    logic            l2_flush_complete;
    logic            in_flush_mode;
    logic            proto_err;

    // L2 model drives m_*, stimulus can inject a stray response through s_rsp.
    logic          m_ack, m_rsp, s_rsp, l2_en;
    logic [DW-1:0] m_data;
    int            ack_dly, rsp_dly;
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            t0;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  opc;
        logic [127:0] sd;
    } exp_req_t;

    typedef struct {
        logic [3:0]   oh;
        logic [127:0] data;
    } exp_rsp_t;

    exp_req_t exp_req_q[$];
    exp_rsp_t exp_rsp_q[$];
    int       exp_fl_q[$];

    assign l2_req_ack       = m_ack;
    assign l2_rsp_valid     = m_rsp | s_rsp;
    assign l2_rsp_load_data = m_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l2_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .OPC_W(OW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_opcode        (req_opcode),
        .req_store_data    (req_store_data),
        .rsp_valid         (rsp_valid),
        .rsp_load_data     (rsp_load_data),
        .l2_req_valid      (l2_req_valid),
        .l2_req_ack        (l2_req_ack),
        .l2_req_addr       (l2_req_addr),
        .l2_req_opcode     (l2_req_opcode),
        .l2_req_store_data (l2_req_store_data),
        .l2_rsp_valid      (l2_rsp_valid),
        .l2_rsp_load_data  (l2_rsp_load_data),
        .flush_req         (flush_req),
        .flush_complete    (flush_complete),
        .l2_flush_req      (l2_flush_req),
        .l2_flush_complete (l2_flush_complete),
        .in_flush_mode     (in_flush_mode),
        .proto_err         (proto_err)
    );

    function automatic logic [127:0] l2_data(input logic [31:0] a);
        return {4{a ^ 32'hAAAA_AAAA}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise one client's request pulse and queue its expected grant and response.
    task automatic issue(input int c, input logic [31:0] addr, input logic [3:0] opc,
                         input logic [127:0] sd, input int exp_cyc, input logic [127:0] rdata);
        exp_req_t er;
        exp_rsp_t es;
        req_addr[c*AW +: AW]       = addr;
        req_opcode[c*OW +: OW]     = opc;
        req_store_data[c*DW +: DW] = sd;
        req_valid[c]               = 1'b1;
        er.cyc = exp_cyc; er.addr = addr; er.opc = opc; er.sd = sd;
        es.oh = 4'(1 << c); es.data = rdata;
        exp_req_q.push_back(er);
        exp_rsp_q.push_back(es);
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while ((exp_req_q.size() + exp_rsp_q.size() + exp_fl_q.size()) != 0 && b < 300) begin
            tick();
            b++;
        end
        if ((exp_req_q.size() + exp_rsp_q.size() + exp_fl_q.size()) != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d events outstanding, expected 0", name,
                     exp_req_q.size() + exp_rsp_q.size() + exp_fl_q.size());
            exp_req_q.delete();
            exp_rsp_q.delete();
            exp_fl_q.delete();
        end
        repeat (2) tick();
    endtask

    initial begin : l2_model
        m_ack = 1'b0; m_rsp = 1'b0; m_data = '0;
        forever begin
            @(posedge clk);
            #1;
            m_ack = 1'b0;
            m_rsp = 1'b0;
            if (l2_req_valid && reset_n && l2_en) begin
                m_data = l2_data(l2_req_addr);
                for (int k = 0; k <= rsp_dly; k++) begin
                    m_ack = (k == ack_dly);
                    m_rsp = (k == rsp_dly);
                    if (k < rsp_dly) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic     prev_v;
        exp_req_t er;
        exp_rsp_t es;
        int       fc;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (l2_req_valid && !prev_v) begin
                if (exp_req_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL grant_unexpected: addr %0h, expected no grant", l2_req_addr);
                end else begin
                    er = exp_req_q.pop_front();
                    check("grant_addr", 128'(l2_req_addr), 128'(er.addr));
                    check("grant_opcode", 128'(l2_req_opcode), 128'(er.opc));
                    check("grant_store_data", l2_req_store_data, er.sd);
                    if (er.cyc >= 0) check("grant_cycle", 128'(cyc), 128'(er.cyc));
                end
            end
            prev_v = l2_req_valid;
            if (rsp_valid != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid %b, expected none", rsp_valid);
                end else begin
                    es = exp_rsp_q.pop_front();
                    check("rsp_onehot", 128'(rsp_valid), 128'(es.oh));
                    check("rsp_data", rsp_load_data, es.data);
                end
            end
            if (l2_flush_req) begin
                if (exp_fl_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL l2_flush_unexpected: pulse at cycle %0d, expected none", cyc);
                end else begin
                    fc = exp_fl_q.pop_front();
                    check("l2_flush_cycle", 128'(cyc), 128'(fc));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset_n = 1'b0; req_valid = '0; req_addr = '0; req_opcode = '0; req_store_data = '0;
        flush_req = '0; flush_complete = '0; l2_flush_complete = 1'b0;
        s_rsp = 1'b0; l2_en = 1'b1; ack_dly = 1; rsp_dly = 3;
        repeat (2) tick();
        check("rst_l2_req_valid", 128'(l2_req_valid), 0);
        check("rst_rsp_valid", 128'(rsp_valid), 0);
        check("rst_proto_err", 128'(proto_err), 0);
        check("rst_in_flush_mode", 128'(in_flush_mode), 0);
        check("rst_l2_flush_req", 128'(l2_flush_req), 0);
        reset_n = 1'b1;
        tick();

        // Two bursts from all clients: both served 0,1,2,3, first grant one cycle after the pulse.
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < N; c++)
                issue(c, 32'h100 * (c + 1), 4'(c + 1), {4{32'hD000 + c}}, (c == 0) ? cyc + 1 : -1,
                      l2_data(32'h100 * (c + 1)));
            tick();
            req_valid = '0;
            drain("fairness");
        end

        // Single request: valid held until ack, response routed to client 2.
        ack_dly = 2; rsp_dly = 4;
        issue(2, 32'h1000, 4'h3, {4{32'h1111_1111}}, cyc + 1, 128'hAAAABAAA_AAAABAAA_AAAABAAA_AAAABAAA);
        tick();
        req_valid = '0;
        repeat (2) tick();
        check("hold_until_ack", 128'(l2_req_valid), 1);
        tick();
        check("drop_after_ack", 128'(l2_req_valid), 0);
        drain("single");

        // Arrival during grant with same-cycle ack and response.
        ack_dly = 2; rsp_dly = 2;
        issue(2, 32'h2000, 4'h5, {4{32'h2222_2222}}, cyc + 1, l2_data(32'h2000));
        tick();
        req_valid = '0;
        tick();
        issue(1, 32'h2100, 4'h6, {4{32'h3333_3333}}, cyc + 3, l2_data(32'h2100));
        tick();
        req_valid = '0;
        drain("arrival");
        check("no_false_proto_err", 128'(proto_err), 0);

        // Flush of clients 0 and 1, with a request arriving while the L2 flush is in progress.
        ack_dly = 1; rsp_dly = 3;
        t0 = cyc;
        flush_req = 4'b0011;
        check("flush_mode_pre", 128'(in_flush_mode), 0);
        tick();
        flush_req = '0;
        check("flush_mode_on", 128'(in_flush_mode), 1);
        repeat (4) tick();
        flush_complete = 4'b0010;
        tick();
        flush_complete = '0;
        repeat (3) tick();
        flush_complete = 4'b0001;
        exp_fl_q.push_back(t0 + 9);
        tick();
        flush_complete = '0;
        issue(3, 32'h3000, 4'h7, {4{32'h4444_4444}}, t0 + 15, l2_data(32'h3000));
        tick();
        req_valid = '0;
        repeat (2) tick();
        check("grant_blocked_in_l2_flush", 128'(l2_req_valid), 0);
        check("flush_mode_hold", 128'(in_flush_mode), 1);
        l2_flush_complete = 1'b1;
        tick();
        l2_flush_complete = 1'b0;
        check("flush_mode_off", 128'(in_flush_mode), 0);
        drain("flush_subset");

        // Flush request and completion in the same cycle.
        flush_req = 4'b0001;
        flush_complete = 4'b0001;
        tick();
        flush_req = '0;
        flush_complete = '0;
        exp_fl_q.push_back(cyc);
        tick();
        l2_flush_complete = 1'b1;
        tick();
        l2_flush_complete = 1'b0;
        check("flush_same_cycle_exit", 128'(in_flush_mode), 0);
        drain("flush_same_cycle");

        // Stray response in IDLE is flagged and the flag sticks.
        s_rsp = 1'b1;
        tick();
        s_rsp = 1'b0;
        check("err_rsp_idle", 128'(proto_err), 1);
        repeat (3) tick();
        check("err_sticky", 128'(proto_err), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("err_cleared_by_reset", 128'(proto_err), 0);

        // Async reset in the middle of a grant.
        l2_en = 1'b0;
        issue(2, 32'h4000, 4'h9, {4{32'h5555_5555}}, cyc + 1, l2_data(32'h4000));
        tick();
        req_valid = '0;
        exp_rsp_q.delete();
        req_valid = 4'b0100;
        flush_req = 4'b0100;
        tick();
        req_valid = '0;
        flush_req = '0;
        check("err_dup_req", 128'(proto_err), 1);
        check("pre_reset_flush_mode", 128'(in_flush_mode), 1);
        check("pre_reset_gnt", 128'(l2_req_valid), 1);
        #2;
        reset_n = 1'b0;
        s_rsp = 1'b1;
        #1;
        check("arst_l2_req_valid", 128'(l2_req_valid), 0);
        check("arst_rsp_valid", 128'(rsp_valid), 0);
        check("arst_in_flush_mode", 128'(in_flush_mode), 0);
        check("arst_proto_err", 128'(proto_err), 0);
        s_rsp = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        l2_en = 1'b1;
        tick();

        // Second flush request while already flushing.
        flush_req = 4'b0001;
        tick();
        flush_req = 4'b0001;
        tick();
        flush_req = '0;
        check("err_flush_busy", 128'(proto_err), 1);
        drain("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
